// File: rtl/bus_byte_driver_if.sv
// Signal bundle between the byte driver, its local producer, the bus arbiter
// and the 8-bit tri-state bus buffer.
interface bus_byte_driver_if;
  // Handshakes: din is accepted on an edge with wr=1 when full=0, or when a pop
  // frees a slot on that same edge. req stays high from request until the burst
  // ends. Each cycle with gnt=1 in the drive phase transfers one byte.
  // buf_ena=strobe=1 qualifies buf_data for the whole of that cycle.
  logic [7:0] din;
  logic       wr;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       req;
  logic       gnt;
  logic [7:0] buf_data;
  logic       buf_ena;
  logic       strobe;
  logic [1:0] dbg_state;

  modport master (
    input  din, wr, gnt,
    output full, empty, ovf, req, buf_data, buf_ena, strobe, dbg_state
  );

  modport slave (
    output din, wr, gnt,
    input  full, empty, ovf, req, buf_data, buf_ena, strobe, dbg_state
  );
endinterface

// File: rtl/bus_byte_driver.sv
// Queues producer bytes, requests the shared bus, and bursts them onto the
// tri-state buffer. An idle turnaround gap follows every burst.
module bus_byte_driver #(
    parameter int DEPTH      = 4,
    parameter int TURNAROUND = 1
) (
    input logic                clk,
    input logic                rst,
    bus_byte_driver_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQUEST, DRIVE, TURN} state_t;

    state_t          state, state_n;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_n;
    logic [2:0]      tcnt;
    logic            full, empty, push, pop, ovf;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = (state == DRIVE) && bus.gnt;
    // A pop on the same edge frees a slot, so a write is accepted even when full.
    assign push    = bus.wr && (!full || pop);
    assign count_n = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            if (bus.wr && full && !pop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.din;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (count != '0) state_n = REQUEST;
            REQUEST: if (bus.gnt) state_n = DRIVE;
            // Losing the grant mid-burst aborts without popping; the head byte is retried.
            DRIVE:   if (!bus.gnt || count_n == '0) state_n = TURN;
            TURN:    if (tcnt == '0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
        end else if (state != TURN && state_n == TURN) begin
            tcnt <= 3'(TURNAROUND - 1);
        end else if (state == TURN && tcnt != '0) begin
            tcnt <= tcnt - 1'b1;
        end
    end

    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.ovf       = ovf;
    assign bus.req       = (state == REQUEST) || (state == DRIVE);
    assign bus.buf_ena   = (state == DRIVE);
    assign bus.strobe    = (state == DRIVE);
    assign bus.buf_data  = (state == DRIVE) ? mem[rd_ptr] : 8'h00;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_bus_byte_driver.sv
// Directed bench for bus_byte_driver: one instance with TURNAROUND=1 and one
// with TURNAROUND=3, driven from a single clock and reset.
module tb_bus_byte_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int gap;

  bus_byte_driver_if b1 ();
  bus_byte_driver_if b3 ();

  bus_byte_driver #(.DEPTH(4), .TURNAROUND(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  bus_byte_driver #(.DEPTH(4), .TURNAROUND(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    b1.din = 8'h00; b1.wr = 1'b0; b1.gnt = 1'b0;
    b3.din = 8'h00; b3.wr = 1'b0; b3.gnt = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // reset values
    check("rst_empty", b1.empty, 1);
    check("rst_full", b1.full, 0);
    check("rst_ovf", b1.ovf, 0);
    check("rst_req", b1.req, 0);
    check("rst_ena", b1.buf_ena, 0);
    check("rst_strobe", b1.strobe, 0);
    check("rst_data", b1.buf_data, 8'h00);

    // single byte latency
    b1.gnt = 1'b1; b1.din = 8'hA5; b1.wr = 1'b1;
    step();
    b1.wr = 1'b0;
    check("t1_empty", b1.empty, 0);
    check("t1_req0", b1.req, 0);
    step();
    check("t1_req1", b1.req, 1);
    check("t1_ena0", b1.buf_ena, 0);
    step();
    check("t1_ena1", b1.buf_ena, 1);
    check("t1_strobe", b1.strobe, 1);
    check("t1_data", b1.buf_data, 8'hA5);
    step();
    check("t1_turn_ena", b1.buf_ena, 0);
    check("t1_turn_req", b1.req, 0);
    check("t1_turn_data", b1.buf_data, 8'h00);
    check("t1_turn_empty", b1.empty, 1);
    step();
    check("t1_idle_req", b1.req, 0);
    check("t1_idle_ena", b1.buf_ena, 0);

    // fill, overflow, then drain with grant
    b1.gnt = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      b1.din = 8'(i); b1.wr = 1'b1;
      exp_q.push_back(8'(i));
      step();
    end
    check("t2_full", b1.full, 1);
    check("t2_ovf_pre", b1.ovf, 0);
    b1.din = 8'h05;
    step();
    b1.wr = 1'b0;
    check("t2_full_hold", b1.full, 1);
    check("t2_ovf", b1.ovf, 1);
    check("t2_req", b1.req, 1);
    check("t2_ena", b1.buf_ena, 0);
    b1.gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_b = exp_q.pop_front();
      check("t2_burst_ena", b1.buf_ena, 1);
      check("t2_burst_data", b1.buf_data, exp_b);
    end
    step();
    check("t2_turn_ena", b1.buf_ena, 0);
    check("t2_turn_req", b1.req, 0);
    check("t2_drop_empty", b1.empty, 1);
    step();

    // streaming writes during a burst
    for (int i = 0; i < 6; i++) begin
      b1.din = 8'(8'h10 + i); b1.wr = 1'b1;
      exp_q.push_back(8'(8'h10 + i));
      step();
      if (i >= 2) begin
        exp_b = exp_q.pop_front();
        check("t3_ena", b1.buf_ena, 1);
        check("t3_data", b1.buf_data, exp_b);
        check("t3_not_full", b1.full, 0);
      end
    end
    b1.wr = 1'b0;
    for (int j = 0; j < 2; j++) begin
      step();
      exp_b = exp_q.pop_front();
      check("t3_drain_ena", b1.buf_ena, 1);
      check("t3_drain_data", b1.buf_data, exp_b);
    end
    step();
    check("t3_end_ena", b1.buf_ena, 0);
    check("t3_end_empty", b1.empty, 1);
    step();

    // grant withheld, then abort mid-burst
    b1.gnt = 1'b0;
    b1.din = 8'hB0; b1.wr = 1'b1;
    step();
    b1.din = 8'hB1;
    step();
    b1.wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4_wait_ena", b1.buf_ena, 0);
    end
    check("t4_wait_req", b1.req, 1);
    check("t4_wait_full", b1.full, 0);
    b1.gnt = 1'b1;
    step();
    check("t4_drv_data", b1.buf_data, 8'hB0);
    b1.gnt = 1'b0;
    step();
    check("t4_abort_ena", b1.buf_ena, 0);
    check("t4_abort_req", b1.req, 0);
    step();
    step();
    check("t4_rereq", b1.req, 1);
    b1.gnt = 1'b1;
    step();
    check("t4_retry_ena", b1.buf_ena, 1);
    check("t4_retry_data", b1.buf_data, 8'hB0);
    step();
    check("t4_next_data", b1.buf_data, 8'hB1);
    step();
    check("t4_turn_ena", b1.buf_ena, 0);
    check("t4_empty", b1.empty, 1);
    check("t4_ovf_sticky", b1.ovf, 1);
    step();

    // turnaround gap with TURNAROUND=3
    b3.gnt = 1'b1; b3.din = 8'hC0; b3.wr = 1'b1;
    step();
    b3.wr = 1'b0;
    step();
    step();
    check("t5_first_ena", b3.buf_ena, 1);
    check("t5_first_data", b3.buf_data, 8'hC0);
    step();
    b3.din = 8'hC1; b3.wr = 1'b1;
    gap = 0;
    for (int k = 0; k < 40; k++) begin
      if (b3.buf_ena) break;
      gap++;
      step();
      b3.wr = 1'b0;
    end
    check("t5_gap", gap, 5);
    check("t5_second_ena", b3.buf_ena, 1);
    check("t5_second_data", b3.buf_data, 8'hC1);
    step();
    check("t5_turn_ena", b3.buf_ena, 0);

    // reset during a burst with bytes queued
    b1.gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b1.din = 8'(8'hD0 + i); b1.wr = 1'b1;
      step();
    end
    b1.wr = 1'b0;
    b1.gnt = 1'b1;
    step();
    check("t6_drv_data", b1.buf_data, 8'hD0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_ena", b1.buf_ena, 0);
    check("t6_req", b1.req, 0);
    check("t6_empty", b1.empty, 1);
    check("t6_ovf", b1.ovf, 0);
    check("t6_data", b1.buf_data, 8'h00);
    check("t6_strobe", b1.strobe, 0);
    step();
    check("t6_stay_idle", b1.req, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_byte_driver.md
Name: bus_byte_driver

Overview:
- Upstream feeder for the 8-bit tri-state bus buffer: generates that buffer's data (IN) and enable (ENA).
- Queues bytes from a local producer in a small FIFO, requests the shared bus from the arbiter, and drives queued bytes in a burst once granted.
- Releases the bus with a guaranteed idle turnaround gap, so two drivers never overlap on the shared 8-bit bus.

Parameters:
- DEPTH, 4: FIFO depth in bytes; power of 2, 2..16.
- TURNAROUND, 1: idle cycles after a burst with BUF_ENA=0 and REQ=0; 1..7.

Ports:
- CLK  input  1  system clock; all logic rising-edge.
- RST  input  1  synchronous reset, active-high.
- DIN  input  8  byte from local producer.
- WR  input  1  write strobe; DIN is pushed at the edge if not FULL.
- FULL  output  1  FIFO holds DEPTH bytes.
- EMPTY  output  1  FIFO holds 0 bytes.
- OVF  output  1  sticky: a write was attempted while FULL.
- REQ  output  1  bus request to arbiter.
- GNT  input  1  bus grant from arbiter.
- BUF_DATA  output  8  to tri-state buffer IN.
- BUF_ENA  output  1  to tri-state buffer ENA.
- STROBE  output  1  byte-valid qualifier on the bus; equal to BUF_ENA.

Behaviour:
- Interface (fixed): one clock, CLK; reset RST is synchronous and active-high.
- Reset values: FIFO emptied, pointers and count 0, state IDLE, turnaround counter 0.
  - Outputs: EMPTY=1, FULL=0, OVF=0, REQ=0, BUF_ENA=0, STROBE=0, BUF_DATA=8'h00.
- Reset mid-burst takes effect at that edge: BUF_ENA=0 the next cycle, and all queued bytes are discarded.
- FIFO:
  - Circular buffer with count width clog2(DEPTH)+1.
  - Pointers wrap from DEPTH-1 to 0.
  - Push when WR & ~FULL. Pop when state==DRIVE & GNT.
  - Simultaneous push and pop: count unchanged. This is allowed when FULL, because a pop frees the slot in the same edge.
  - WR & FULL & ~pop: data dropped, OVF set; OVF is cleared only by RST.
  - FULL and EMPTY decode from the count register (no combinational path from WR).
- FSM (registered state):
  - IDLE: REQ=0. If count!=0, go to REQUEST.
  - REQUEST: REQ=1. If GNT, go to DRIVE; otherwise stay.
  - DRIVE: REQ=1, BUF_ENA=STROBE=1, BUF_DATA=FIFO head.
    - GNT=1: pop at the edge. Stay in DRIVE if the post-edge count is nonzero (including a simultaneous push); otherwise go to TURN.
    - GNT=0 is an arbiter protocol violation, treated as an abort: no pop, go to TURN, and the byte is retried in the next burst.
  - TURN: REQ=0, BUF_ENA=0. Load counter with TURNAROUND-1 on entry and decrement each cycle. At 0, go to IDLE.
- Output rules:
  - BUF_ENA, STROBE and REQ are decoded from the state register only (glitch-free, no GNT combinational path).
  - BUF_DATA=8'h00 whenever BUF_ENA=0.
- Latency with GNT held 1, from a single write at edge k:
  - EMPTY falls after edge k.
  - REQ rises after edge k+1.
  - BUF_ENA=1 for exactly one cycle after edge k+2.
  - TURN lasts TURNAROUND cycles, then IDLE.
- Throughput: one byte per cycle during a burst, with no bubbles while the FIFO stays non-empty.
- Minimum gap between bursts: TURNAROUND+2 cycles of BUF_ENA=0 (TURN, IDLE, REQUEST).

Test Plan:
- Reset, then write 8'hA5 with GNT=1 -> EMPTY=0 one cycle after the write edge. Next cycle REQ=1. Next cycle BUF_ENA=1 and BUF_DATA=8'hA5 for exactly 1 cycle, then BUF_ENA=0 and REQ=0 for 1 cycle, then IDLE with EMPTY=1.
- DEPTH=4: write 8'h01..8'h04 back-to-back, then a 5th write 8'h05 with GNT=0 -> FULL=1, OVF=1, 8'h05 dropped, REQ=1 held. Raise GNT -> bus carries 01,02,03,04 on consecutive cycles, then TURN.
- During a burst, write one new byte each cycle while popping -> burst continues without a bubble and count stays constant. Stop writing -> burst ends after the queued bytes drain.
- Hold GNT=0 for 10 cycles after REQ rises -> BUF_ENA stays 0 and nothing pops. Deassert GNT during DRIVE (abort) -> no pop, TURN entered, and the same byte reappears first in the next burst.
- TURNAROUND=3, two bursts requested back-to-back -> at least 5 cycles with BUF_ENA=0 between the last byte of burst 1 and the first byte of burst 2.
- Assert RST during DRIVE with 3 bytes queued -> next cycle BUF_ENA=0, REQ=0, EMPTY=1, OVF=0, BUF_DATA=8'h00.
